// File: rtl/cpu_pkg.sv
// cpu_pkg: shared CPU-slice types and widths used by the memory data register reader.
package cpu_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } mdr_state_t;

endpackage

// File: rtl/mdr_reader_if.sv
// mdr_reader_if: request/acknowledge memory read port; mem_data is valid with mem_ack.
interface mdr_reader_if
  import cpu_pkg::*;
#(
  parameter int ADDR_W = WORD_W,
  parameter int DATA_W = WORD_W
);
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_data;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_ack,
    input  mem_data
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_ack,
    output mem_data
  );
endinterface

// File: rtl/mdr_reader_timeout_counter.sv
// timeout_counter: counts consecutive enabled cycles and flags the LIMIT-th one.
module timeout_counter #(
  parameter int LIMIT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic expired
);
  logic [7:0] count;

  // count holds the number of completed enabled cycles, so the current one is count+1
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      count <= '0;
    end else begin
      count <= count + 8'd1;
    end
  end

  assign expired = en && (count == 8'(LIMIT - 1));
endmodule

// File: rtl/mdr_reader.sv
// mdr_reader: issues one memory read per start and captures the returned word in the MDR.
// Defining MDR_TIMEOUT_EN abandons requests left unacknowledged for TIMEOUT cycles.
module mdr_reader
  import cpu_pkg::*;
#(
  parameter int ADDR_W  = WORD_W,
  parameter int DATA_W  = WORD_W,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] addr,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] rdata,
  mdr_reader_if.master      mem
);
  mdr_state_t state;
  logic       timeout_hit;

  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("mdr_reader: TIMEOUT must lie in 1..255");
  end

`ifdef MDR_TIMEOUT_EN
  timeout_counter #(
    .LIMIT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .en      (state == REQ && !mem.mem_ack),
    .expired (timeout_hit)
  );
`else
  assign timeout_hit = 1'b0;
`endif

  // an ack landing in the expiry cycle wins, so a late but valid read still completes cleanly
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      rdata        <= '0;
      mem.mem_req  <= 1'b0;
      mem.mem_addr <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state        <= REQ;
            busy         <= 1'b1;
            err          <= 1'b0;
            mem.mem_req  <= 1'b1;
            mem.mem_addr <= addr;
          end
        end
        REQ: begin
          if (mem.mem_ack) begin
            state       <= DONE;
            done        <= 1'b1;
            rdata       <= mem.mem_data;
            mem.mem_req <= 1'b0;
          end else if (timeout_hit) begin
            state       <= DONE;
            done        <= 1'b1;
            err         <= 1'b1;
            mem.mem_req <= 1'b0;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: begin
          state       <= IDLE;
          busy        <= 1'b0;
          done        <= 1'b0;
          mem.mem_req <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mdr_reader.sv
// tb_mdr_reader: directed reads with a done-triggered scoreboard checking rdata and err.
// Timeout scenarios are exercised when MDR_TIMEOUT_EN is defined.
module tb_mdr_reader;
  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] addr;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] rdata;

  int   checks   = 0;
  int   failures = 0;
  exp_t exp_q[$];

  mdr_reader_if #(.ADDR_W(32), .DATA_W(32)) mem_if ();

  mdr_reader #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .TIMEOUT (15)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .addr  (addr),
    .busy  (busy),
    .done  (done),
    .err   (err),
    .rdata (rdata),
    .mem   (mem_if)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // one read: waits ack-free REQ cycles, then acks with data d in the following cycle
  task automatic applyStimulus(input logic [31:0] a, input int wait_cycles, input logic [31:0] d);
    exp_q.push_back('{rdata: d, err: 1'b0});
    start = 1'b1;
    addr  = a;
    @(negedge clk);
    start = 1'b0;
    addr  = 32'hFFFF_FFFF;
    checkOutput("req_on_start", 32'(mem_if.mem_req), 32'd1);
    checkOutput("busy_on_start", 32'(busy), 32'd1);
    checkOutput("err_cleared", 32'(err), 32'd0);
    checkOutput("mem_addr_latched", mem_if.mem_addr, a);
    for (int i = 0; i < wait_cycles; i++) begin
      @(negedge clk);
      checkOutput("req_held", 32'(mem_if.mem_req), 32'd1);
      checkOutput("mem_addr_stable", mem_if.mem_addr, a);
    end
    mem_if.mem_ack  = 1'b1;
    mem_if.mem_data = d;
    @(negedge clk);
    mem_if.mem_ack  = 1'b0;
    mem_if.mem_data = 32'h0BAD_0BAD;
    checkOutput("done_pulse", 32'(done), 32'd1);
    checkOutput("req_dropped", 32'(mem_if.mem_req), 32'd0);
    checkOutput("busy_in_done", 32'(busy), 32'd1);
    @(negedge clk);
    checkOutput("done_cleared", 32'(done), 32'd0);
    checkOutput("busy_idle", 32'(busy), 32'd0);
  endtask

  // scoreboard monitor: every done pulse must match the oldest outstanding expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_done: got done=1 expected no pending read at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          checkOutput("sb_rdata", rdata, e.rdata);
          checkOutput("sb_err", 32'(err), 32'(e.err));
        end
      end
    end
  end

  initial begin
    #200000;
    failures++;
    $display("[TB] FAIL watchdog: got no end of stimulus expected finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst             = 1'b1;
    start           = 1'b0;
    addr            = '0;
    mem_if.mem_ack  = 1'b0;
    mem_if.mem_data = '0;
    repeat (2) @(negedge clk);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_err", 32'(err), 32'd0);
    checkOutput("rst_req", 32'(mem_if.mem_req), 32'd0);
    checkOutput("rst_mem_addr", mem_if.mem_addr, 32'd0);
    checkOutput("rst_rdata", rdata, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] basic read");
    applyStimulus(32'h0000_0040, 3, 32'hDEAD_BEEF);
    checkOutput("basic_rdata_held", rdata, 32'hDEAD_BEEF);

    $display("[TB] minimum latency read");
    applyStimulus(32'h0000_0044, 0, 32'h1234_5678);

    $display("[TB] ack pulses while idle");
    mem_if.mem_ack  = 1'b1;
    mem_if.mem_data = 32'hFFFF_0000;
    repeat (3) begin
      @(negedge clk);
      checkOutput("idle_ack_rdata", rdata, 32'h1234_5678);
      checkOutput("idle_ack_done", 32'(done), 32'd0);
      checkOutput("idle_ack_busy", 32'(busy), 32'd0);
    end
    mem_if.mem_ack = 1'b0;

    $display("[TB] back-to-back reads with start held");
    exp_q.push_back('{rdata: 32'hB000_0001, err: 1'b0});
    exp_q.push_back('{rdata: 32'hB000_0004, err: 1'b0});
    exp_q.push_back('{rdata: 32'hB000_0007, err: 1'b0});
    exp_q.push_back('{rdata: 32'hB000_000A, err: 1'b0});
    mem_if.mem_ack = 1'b1;
    for (int i = 0; i <= 10; i++) begin
      start           = (i < 10);
      addr            = 32'h0000_0100 + 32'(4 * i);
      mem_if.mem_data = 32'hB000_0000 + 32'(i);
      @(negedge clk);
      // edges 1,4,7,10 accept; the edge after each acks; the next returns to idle
      checkOutput("b2b_req", 32'(mem_if.mem_req), 32'(((i + 1) % 3) == 1));
      checkOutput("b2b_busy", 32'(busy), 32'(((i + 1) % 3) != 0));
      if (((i + 1) % 3) == 1) begin
        checkOutput("b2b_mem_addr", mem_if.mem_addr, 32'h0000_0100 + 32'(4 * i));
      end
    end
    mem_if.mem_ack = 1'b0;
    start          = 1'b0;
    @(negedge clk);
    checkOutput("b2b_final_rdata", rdata, 32'hB000_000A);

`ifdef MDR_TIMEOUT_EN
    $display("[TB] timeout with no ack");
    exp_q.push_back('{rdata: 32'hB000_000A, err: 1'b1});
    start = 1'b1;
    addr  = 32'h0000_0200;
    @(negedge clk);
    start = 1'b0;
    checkOutput("to_req_cycle1", 32'(mem_if.mem_req), 32'd1);
    for (int j = 2; j <= 15; j++) begin
      @(negedge clk);
      checkOutput("to_req_held", 32'(mem_if.mem_req), 32'd1);
      checkOutput("to_no_done", 32'(done), 32'd0);
    end
    @(negedge clk);
    checkOutput("to_req_dropped", 32'(mem_if.mem_req), 32'd0);
    checkOutput("to_done", 32'(done), 32'd1);
    checkOutput("to_err", 32'(err), 32'd1);
    checkOutput("to_rdata_kept", rdata, 32'hB000_000A);
    @(negedge clk);
    checkOutput("to_err_sticky", 32'(err), 32'd1);
    checkOutput("to_idle", 32'(busy), 32'd0);
    $display("[TB] ack in the expiry cycle completes normally");
    applyStimulus(32'h0000_0204, 14, 32'h0BAD_F00D);
`else
    $display("[TB] long wait without timeout");
    applyStimulus(32'h0000_0204, 20, 32'h0BAD_F00D);
`endif
    checkOutput("late_ack_rdata", rdata, 32'h0BAD_F00D);

    $display("[TB] reset during request");
    start = 1'b1;
    addr  = 32'h0000_0300;
    @(negedge clk);
    start = 1'b0;
    checkOutput("rstreq_req_on", 32'(mem_if.mem_req), 32'd1);
    rst             = 1'b1;
    mem_if.mem_ack  = 1'b1;
    mem_if.mem_data = 32'h5555_5555;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("rstreq_req_off", 32'(mem_if.mem_req), 32'd0);
    checkOutput("rstreq_rdata", rdata, 32'd0);
    checkOutput("rstreq_done", 32'(done), 32'd0);
    checkOutput("rstreq_busy", 32'(busy), 32'd0);
    checkOutput("rstreq_mem_addr", mem_if.mem_addr, 32'd0);
    repeat (3) begin
      @(negedge clk);
      checkOutput("rstreq_ack_ignored", rdata, 32'd0);
      checkOutput("rstreq_no_done", 32'(done), 32'd0);
      checkOutput("rstreq_still_idle", 32'(busy), 32'd0);
    end
    mem_if.mem_ack = 1'b0;

    @(negedge clk);
    checkOutput("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mdr_reader.md
MDR_READER -- requirements
Module: mdr_reader

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning address width.
REQ-002 SHALL have parameter DATA_W, default 32, meaning data width.
REQ-003 SHALL have parameter TIMEOUT, default 15, meaning maximum unacknowledged request cycles (1..255).
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-006 SHALL have port start, input, 1, read command.
REQ-007 SHALL have port addr, input, ADDR_W, read address, sampled with start.
REQ-008 SHALL have port busy, output, 1, high when not in IDLE.
REQ-009 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-010 SHALL have port err, output, 1, sticky timeout flag.
REQ-011 SHALL have port rdata, output, DATA_W, memory data register (MDR) contents.
REQ-012 SHALL have port mem_req, output, 1, memory read request.
REQ-013 SHALL have port mem_addr, output, ADDR_W, registered request address.
REQ-014 SHALL have port mem_ack, input, 1, memory acknowledge; mem_data is valid in the same cycle.
REQ-015 SHALL have port mem_data, input, DATA_W, memory read data.

Function
REQ-016 SHALL implement the states IDLE, REQ and DONE; busy is high in REQ and DONE.
REQ-017 SHALL, when start=1 in IDLE at edge n, latch addr into mem_addr, enter REQ and drive mem_req=1 from cycle n+1.
REQ-018 SHALL hold mem_req=1 and mem_addr stable in REQ until mem_ack=1 is sampled.
REQ-019 SHALL, when mem_ack=1 is sampled in REQ at edge m, load mem_data into rdata, drop mem_req, and enter DONE with done=1 during cycle m+1.
REQ-020 SHALL leave DONE for IDLE after exactly one cycle; minimum start-to-done latency is 2 cycles.
REQ-021 SHALL ignore start in REQ and DONE; a start held high is accepted in the first cycle back in IDLE.
REQ-022 SHALL ignore mem_ack in IDLE and DONE, and SHALL leave rdata unchanged in those states.
REQ-023 SHALL hold rdata between reads; it changes only on an acknowledged read.
REQ-024 SHALL clear err on each accepted start.

Reset
REQ-025 SHALL, when rst=1 at an edge, force IDLE, busy=0, done=0, err=0, mem_req=0, mem_addr=0, rdata=0, and clear the timeout counter.
REQ-026 SHALL give rst priority over start and mem_ack; reset in REQ drops mem_req at that edge with no done pulse.

Configuration
REQ-027 SHALL, with MDR_TIMEOUT_EN defined, count REQ cycles without mem_ack; when the count reaches TIMEOUT, drop mem_req, set err=1, leave rdata unchanged, and enter DONE (done pulses).
REQ-028 SHALL, if mem_ack=1 arrives in the same cycle the count reaches TIMEOUT, treat it as a normal completion (err stays 0).
REQ-029 SHALL, without MDR_TIMEOUT_EN, wait indefinitely in REQ and tie err to 0.

Structure
REQ-030 SHALL take the state encoding typedef (IDLE/REQ/DONE) and the default word width from the shared package cpu_pkg.
REQ-031 SHALL place the timeout counter in sub-module timeout_counter, instantiated only under MDR_TIMEOUT_EN.

Verification
REQ-032 SHALL verify a basic read: start, addr=0x00000040; ack after 3 cycles with mem_data=0xDEADBEEF -> rdata=0xDEADBEEF and one done pulse, err=0.
REQ-033 SHALL verify minimum latency: ack in the first REQ cycle -> done 2 cycles after start.
REQ-034 SHALL verify back-to-back reads: start held high for 10 cycles -> reads accepted at the 1st and 4th edges (zero-wait ack), mem_addr stable throughout REQ.
REQ-035 SHALL verify timeout (MDR_TIMEOUT_EN, TIMEOUT=15): no ack -> mem_req drops after 15 REQ cycles, err=1, done pulses, rdata keeps its prior value; the next start clears err.
REQ-036 SHALL verify reset in REQ: rst pulse -> mem_req=0, rdata=0 and no done pulse; a later mem_ack is ignored.
REQ-037 SHALL verify mem_ack=1 pulses in IDLE -> no change to rdata, done or busy.
